hex_scan_controller: RTL



---
 rtl/hex_scan_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-multiplexes one external 4-bit-to-7-segment
// decoder across NUM_DIGITS common-anode digits. Each digit slot begins with a
// blanking guard. New frames arrive over a valid/ready handshake and are only
// swapped in at a frame boundary, so a frame never mixes old and new data.
module hex_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   output logic [3:0]              dec_nibble,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_n,
   output logic                    frame_done
);

   localparam int CNTW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PRESCALE - 1);
   localparam logic [CNTW-1:0] CNT_SHOW = CNTW'(BLANK_CYCLES);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DIGITS - 1);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("hex_scan_controller: NUM_DIGITS must be in 1..8");
   end
   if (BLANK_CYCLES < 1) begin : g_bad_blank_cycles
      $error("hex_scan_controller: BLANK_CYCLES must be at least 1");
   end
   if (PRESCALE <= BLANK_CYCLES) begin : g_bad_prescale
      $error("hex_scan_controller: PRESCALE must exceed BLANK_CYCLES");
   end

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [CNTW-1:0]                cnt;
   logic [CNTW-1:0]                cnt_nxt;
   logic [IDXW-1:0]                idx;
   logic [IDXW-1:0]                idx_nxt;
   logic                           frame_end;
   logic                           accept;
   logic                           pending;
   logic [NUM_DIGITS-1:0][3:0]     act_nib;
   logic [NUM_DIGITS-1:0]          act_mask;
   logic [NUM_DIGITS-1:0][3:0]     shd_nib;
   logic [NUM_DIGITS-1:0]          shd_mask;

   assign load_ready = ~pending;
   assign accept     = load_valid & load_ready;
   assign dec_nibble = act_nib[idx];

   // Slot timing: advance the slot counter and digit index, and derive the
   // BLANK/SHOW phase from where the counter will sit after this edge.
   always_comb begin
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      state_nxt = state;
      frame_end = 1'b0;
      if (!en) begin
         cnt_nxt   = '0;
         idx_nxt   = '0;
         state_nxt = BLANK;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_end = (idx == IDX_LAST);
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
         state_nxt = (cnt_nxt < CNT_SHOW) ? BLANK : SHOW;
      end
   end

   // Scan state register: phase, position within the slot, and current digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Frame storage: park an accepted frame in the shadow, promote it to the
   // active copy only at a frame end so the display never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_nib  <= '0;
         act_mask <= '1;
         shd_nib  <= '0;
         shd_mask <= '1;
         pending  <= 1'b0;
      end else begin
         if (frame_end && pending) begin
            act_nib  <= shd_nib;
            act_mask <= shd_mask;
            pending  <= 1'b0;
         end else if (accept) begin
            shd_nib  <= load_data;
            shd_mask <= load_blank;
            pending  <= 1'b1;
         end
      end
   end

   // Pin drivers: register segments and digit enable from the current phase,
   // keeping everything dark during the guard or while scanning is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= 7'h7F;
         dig_n      <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (en && state == SHOW) begin
            seg   <= act_mask[idx] ? 7'h7F : dec_seg;
            dig_n <= ~(NUM_DIGITS'(1) << idx);
         end else begin
            seg   <= 7'h7F;
            dig_n <= '1;
         end
      end
   end

endmodule
